// File: rtl/up_counter_pkg.sv
// Shared state encoding and default sizing for the up counter control slice.
package up_counter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam int unsigned DEF_WIDTH    = 12;
   localparam int unsigned DEF_PRESCALE = 4;

   function automatic int unsigned presc_bits(int unsigned p);
      return (p > 1) ? $clog2(p) : 1;
   endfunction

endpackage

// File: rtl/up_counter_ctrl_tick_gen.sv
// Prescaler for the counter: counts 0..PRESCALE-1 while enabled,
// emits a 1-cycle tick on the cycle it wraps back to 0.
module tick_gen
   import up_counter_pkg::*;
#(
   parameter int unsigned PRESCALE = DEF_PRESCALE
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic restart,
   output logic tick
);

   localparam int unsigned PW = presc_bits(PRESCALE);
   localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] cnt;

   assign tick = en && !restart && (cnt == LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (restart) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= (cnt == LAST) ? '0 : cnt + PW'(1);
      end
   end

endmodule

// File: rtl/up_counter_ctrl.sv
// Run/stop sequencer for the up counter with valid/ready update handshake.
// Optional pause input enabled by defining UP_COUNTER_CTRL_PAUSE_EN.
module up_counter_ctrl
   import up_counter_pkg::*;
#(
   parameter int unsigned WIDTH    = DEF_WIDTH,
   parameter int unsigned PRESCALE = DEF_PRESCALE
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic             clear,
   input  logic             wrap,
   input  logic [WIDTH-1:0] limit,
`ifdef UP_COUNTER_CTRL_PAUSE_EN
   input  logic             pause,
`endif
   output logic [WIDTH-1:0] count,
   output logic             running,
   output logic             done,
   output logic             upd_valid,
   input  logic             upd_ready
);

   state_t state;
   logic   stop_pend;
   logic   pause_i;
   logic   tick;
   logic   tg_en;
   logic   tg_restart;

`ifdef UP_COUNTER_CTRL_PAUSE_EN
   assign pause_i = pause;
`else
   assign pause_i = 1'b0;
`endif

   // HOLD neither advances nor restarts, so the phase survives the handshake
   assign tg_en      = (state == RUN) && !pause_i;
   assign tg_restart = clear
                    || (state == IDLE)
                    || (state == DONE)
                    || ((state == RUN) && stop);

   tick_gen #(
      .PRESCALE (PRESCALE)
   ) u_tick (
      .clk     (clk),
      .rst     (rst),
      .en      (tg_en),
      .restart (tg_restart),
      .tick    (tick)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         count     <= '0;
         running   <= 1'b0;
         done      <= 1'b0;
         upd_valid <= 1'b0;
         stop_pend <= 1'b0;
      end else if (clear) begin
         state     <= IDLE;
         count     <= '0;
         running   <= 1'b0;
         done      <= 1'b0;
         upd_valid <= 1'b0;
         stop_pend <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               stop_pend <= 1'b0;
               if (start && !stop) begin
                  state   <= RUN;
                  running <= 1'b1;
               end
            end
            RUN: begin
               if (stop) begin
                  state   <= IDLE;
                  running <= 1'b0;
               end else if (tick) begin
                  if (count < limit) begin
                     count     <= count + WIDTH'(1);
                     upd_valid <= 1'b1;
                     state     <= HOLD;
                  end else if (wrap) begin
                     count     <= '0;
                     upd_valid <= 1'b1;
                     state     <= HOLD;
                  end else begin
                     state   <= DONE;
                     done    <= 1'b1;
                     running <= 1'b0;
                  end
               end
            end
            HOLD: begin
               if (upd_valid && upd_ready) begin
                  upd_valid <= 1'b0;
                  stop_pend <= 1'b0;
                  if (stop || stop_pend) begin
                     state   <= IDLE;
                     running <= 1'b0;
                  end else begin
                     state <= RUN;
                  end
               end else if (stop) begin
                  stop_pend <= 1'b1;
               end
            end
            DONE: begin
               if (start && !stop) begin
                  count     <= '0;
                  done      <= 1'b0;
                  upd_valid <= 1'b1;
                  running   <= 1'b1;
                  state     <= HOLD;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
